num_entry_buffer: RTL and testbench

- Parametrised successor to the single-key scancode-to-digit decoder.
- Accepts PS/2 make-code events (9-bit, bit 8 = E0 extended) and accumulates up to DIGITS decimal digits in a right-aligned BCD shift buffer for the 7-seg display path.
- Supports backspace and clear; main Enter and keypad Enter commit the entry.
- On commit, a sequential BCD-to-binary converter produces the binary value, which is offered to downstream game logic through a valid/ready handshake.

---
 rtl/num_entry_buffer_if.sv | 32 +++
 rtl/num_entry_buffer.sv | 179 +++++++++++++++++
 tb/tb_num_entry_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/num_entry_buffer_if.sv
// num_entry_buffer_if: groups the key-event input, the digit-display outputs and the
// committed-value valid/ready handshake of num_entry_buffer.
//   key_valid/key_code : one-cycle make-code event (bit 8 = E0 extended)
//   digits/count       : right-aligned BCD buffer (4'hF = blank) and digit count
//   overflow/busy      : sticky dropped-digit flag, conversion/hold in progress
//   out_valid/out_ready/out_value : committed binary value handshake
// master drives keys and out_ready; slave is the buffer itself.
interface num_entry_buffer_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned VAL_W  = 14,
    parameter int unsigned CNT_W  = 3
);
    logic                  key_valid;
    logic [8:0]            key_code;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   digits;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  busy;
    logic                  out_valid;
    logic [VAL_W-1:0]      out_value;

    modport master (
        output key_valid, key_code, out_ready,
        input  digits, count, overflow, busy, out_valid, out_value
    );

    modport slave (
        input  key_valid, key_code, out_ready,
        output digits, count, overflow, busy, out_valid, out_value
    );
endinterface

// File: rtl/num_entry_buffer.sv
// num_entry_buffer: accumulates PS/2 digit make codes into a right-aligned BCD buffer
// (slot 0 = newest digit, 4'hF = blank) with backspace and clear. Enter (main or keypad)
// starts a one-digit-per-clock BCD-to-binary conversion; the result is then held on a
// valid/ready handshake until downstream accepts it, which also empties the buffer.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : num_entry_buffer_if.slave (key events, display outputs, result handshake)
module num_entry_buffer #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned VAL_W     = 14,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned NUMPAD_EN = 1
) (
    input logic              clk,
    input logic              rst_n,
    num_entry_buffer_if.slave bus
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {StEntry, StConvert, StHold} state_e;

    state_e              state_q, state_d;
    logic [4*DIGITS-1:0] digits_q, digits_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                overflow_q, overflow_d;
    logic [VAL_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                out_valid_q, out_valid_d;
    logic [VAL_W-1:0]    out_value_q, out_value_d;
    logic                busy_q, busy_d;

    logic       key_is_digit, key_bs, key_esc, key_enter;
    logic [3:0] key_digit;
    logic [3:0] slot_cur;
    logic [VAL_W-1:0] acc_next;

    // Key decode
    always_comb begin
        key_is_digit = 1'b0;
        key_digit    = 4'h0;
        key_bs       = 1'b0;
        key_esc      = 1'b0;
        key_enter    = 1'b0;
        case (bus.key_code)
            9'h045: begin key_is_digit = 1'b1; key_digit = 4'd0; end
            9'h016: begin key_is_digit = 1'b1; key_digit = 4'd1; end
            9'h01E: begin key_is_digit = 1'b1; key_digit = 4'd2; end
            9'h026: begin key_is_digit = 1'b1; key_digit = 4'd3; end
            9'h025: begin key_is_digit = 1'b1; key_digit = 4'd4; end
            9'h02E: begin key_is_digit = 1'b1; key_digit = 4'd5; end
            9'h036: begin key_is_digit = 1'b1; key_digit = 4'd6; end
            9'h03D: begin key_is_digit = 1'b1; key_digit = 4'd7; end
            9'h03E: begin key_is_digit = 1'b1; key_digit = 4'd8; end
            9'h046: begin key_is_digit = 1'b1; key_digit = 4'd9; end
            9'h066: key_bs    = 1'b1;
            9'h076: key_esc   = 1'b1;
            9'h05A: key_enter = 1'b1;
            9'h15A: key_enter = 1'b1;
            default: ;
        endcase
        if (NUMPAD_EN != 0) begin
            case (bus.key_code)
                9'h070: begin key_is_digit = 1'b1; key_digit = 4'd0; end
                9'h069: begin key_is_digit = 1'b1; key_digit = 4'd1; end
                9'h072: begin key_is_digit = 1'b1; key_digit = 4'd2; end
                9'h07A: begin key_is_digit = 1'b1; key_digit = 4'd3; end
                9'h06B: begin key_is_digit = 1'b1; key_digit = 4'd4; end
                9'h073: begin key_is_digit = 1'b1; key_digit = 4'd5; end
                9'h074: begin key_is_digit = 1'b1; key_digit = 4'd6; end
                9'h06C: begin key_is_digit = 1'b1; key_digit = 4'd7; end
                9'h075: begin key_is_digit = 1'b1; key_digit = 4'd8; end
                9'h07D: begin key_is_digit = 1'b1; key_digit = 4'd9; end
                default: ;
            endcase
        end
    end

    // Conversion walks from the top slot down; blank slots above the entry are skipped.
    assign slot_cur = digits_q[{idx_q, 2'b00} +: 4];
    assign acc_next = (slot_cur == 4'hF) ? acc_q
                                         : acc_q * VAL_W'(10) + VAL_W'(slot_cur);

    always_comb begin
        state_d     = state_q;
        digits_d    = digits_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_value_d = out_value_q;
        unique case (state_q)
            StEntry: begin
                if (bus.key_valid) begin
                    if (key_is_digit) begin
                        if (count_q < CNT_W'(DIGITS)) begin
                            for (int i = 1; i < int'(DIGITS); i++) begin
                                digits_d[4*i +: 4] = digits_q[4*(i-1) +: 4];
                            end
                            digits_d[3:0] = key_digit;
                            count_d       = count_q + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (key_bs) begin
                        if (count_q != '0) begin
                            for (int i = 0; i < int'(DIGITS) - 1; i++) begin
                                digits_d[4*i +: 4] = digits_q[4*(i+1) +: 4];
                            end
                            digits_d[4*(DIGITS-1) +: 4] = 4'hF;
                            count_d = count_q - CNT_W'(1);
                        end
                    end else if (key_esc) begin
                        digits_d   = '1;
                        count_d    = '0;
                        overflow_d = 1'b0;
                    end else if (key_enter && (count_q != '0)) begin
                        acc_d   = '0;
                        idx_d   = IDX_W'(DIGITS - 1);
                        state_d = StConvert;
                    end
                end
            end
            StConvert: begin
                acc_d = acc_next;
                if (idx_q == '0) begin
                    out_value_d = acc_next;
                    out_valid_d = 1'b1;
                    state_d     = StHold;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            StHold: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    digits_d    = '1;
                    count_d     = '0;
                    overflow_d  = 1'b0;
                    state_d     = StEntry;
                end
            end
            default: state_d = StEntry;
        endcase
        busy_d = (state_d != StEntry);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StEntry;
            digits_q    <= '1;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            acc_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_value_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_value_q <= out_value_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.digits    = digits_q;
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_value = out_value_q;
endmodule

// File: tb/tb_num_entry_buffer.sv
// Bench for num_entry_buffer: directed sequences followed by random key traffic, all
// checked every cycle against a queue-based model of the digit entry; a second instance
// with the keypad disabled is exercised on its own short sequence.
module tb_num_entry_buffer;
    localparam int DIGITS = 4;
    localparam int VAL_W  = 14;
    localparam int CNT_W  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    num_entry_buffer_if #(.DIGITS(DIGITS), .VAL_W(VAL_W), .CNT_W(CNT_W)) bus_a ();
    num_entry_buffer_if #(.DIGITS(DIGITS), .VAL_W(VAL_W), .CNT_W(CNT_W)) bus_b ();

    num_entry_buffer #(.DIGITS(DIGITS), .VAL_W(VAL_W), .CNT_W(CNT_W), .NUMPAD_EN(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    num_entry_buffer #(.DIGITS(DIGITS), .VAL_W(VAL_W), .CNT_W(CNT_W), .NUMPAD_EN(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: entered digits as a queue (oldest first), mode 0/1/2 = entry/convert/hold
    int mq[$];
    bit m_ovf;
    int m_mode;
    int m_left;
    bit m_valid;
    int m_value;

    int main_codes[10]   = '{'h045, 'h016, 'h01E, 'h026, 'h025, 'h02E, 'h036, 'h03D, 'h03E, 'h046};
    int keypad_codes[10] = '{'h070, 'h069, 'h072, 'h07A, 'h06B, 'h073, 'h074, 'h06C, 'h075, 'h07D};

    function automatic int decode_digit(input int code);
        for (int i = 0; i < 10; i++) begin
            if (main_codes[i] == code || keypad_codes[i] == code) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_ovf   = 0;
        m_mode  = 0;
        m_left  = 0;
        m_valid = 0;
        m_value = 0;
    endtask

    task automatic model_edge(input bit kv, input int kc, input bit rdy);
        int d;
        int v;
        if (m_mode == 0) begin
            if (kv) begin
                d = decode_digit(kc);
                if (d >= 0) begin
                    if (mq.size() < DIGITS) mq.push_back(d);
                    else m_ovf = 1;
                end else if (kc == 'h066) begin
                    if (mq.size() > 0) void'(mq.pop_back());
                end else if (kc == 'h076) begin
                    mq.delete();
                    m_ovf = 0;
                end else if ((kc == 'h05A || kc == 'h15A) && mq.size() > 0) begin
                    m_mode = 1;
                    m_left = DIGITS;
                end
            end
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) begin
                v = 0;
                foreach (mq[i]) v = v * 10 + mq[i];
                m_value = v;
                m_valid = 1;
                m_mode  = 2;
            end
        end else if (rdy) begin
            m_valid = 0;
            mq.delete();
            m_ovf  = 0;
            m_mode = 0;
        end
    endtask

    function automatic logic [4*DIGITS-1:0] exp_digits();
        logic [4*DIGITS-1:0] r;
        r = '1;
        for (int i = 0; i < mq.size(); i++) r[4*i +: 4] = 4'(mq[mq.size()-1-i]);
        return r;
    endfunction

    task automatic check_a();
        check_eq("digits",    bus_a.digits,    exp_digits());
        check_eq("count",     bus_a.count,     mq.size());
        check_eq("overflow",  bus_a.overflow,  m_ovf);
        check_eq("busy",      bus_a.busy,      m_mode != 0);
        check_eq("out_valid", bus_a.out_valid, m_valid);
        check_eq("out_value", bus_a.out_value, m_value);
    endtask

    task automatic cycle(input bit kv, input logic [8:0] kc, input bit rdy);
        bus_a.key_valid = kv;
        bus_a.key_code  = kc;
        bus_a.out_ready = rdy;
        @(posedge clk);
        model_edge(kv, int'(kc), rdy);
        @(negedge clk);
        check_a();
    endtask

    task automatic key(input logic [8:0] kc);
        cycle(1'b1, kc, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 9'h000, 1'b0);
    endtask

    // Drives only the keypad-disabled instance; instance A sees idle cycles.
    task automatic cycle_b(input bit kv, input logic [8:0] kc, input bit rdy);
        bus_b.key_valid = kv;
        bus_b.key_code  = kc;
        bus_b.out_ready = rdy;
        cycle(1'b0, 9'h000, 1'b0);
        bus_b.key_valid = 1'b0;
        bus_b.out_ready = 1'b0;
    endtask

    initial begin
        int r;
        logic [8:0] kc;
        bus_a.key_valid = 1'b0; bus_a.key_code = '0; bus_a.out_ready = 1'b0;
        bus_b.key_valid = 1'b0; bus_b.key_code = '0; bus_b.out_ready = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        #2 check_a();
        @(negedge clk);
        rst_n = 1'b1;

        // 1,2,3 then Enter: four-edge latency, then held while out_ready is low
        key(9'h016); key(9'h01E); key(9'h026);
        check_eq("plan1_digits", bus_a.digits, 16'hF123);
        check_eq("plan1_count",  bus_a.count,  3);
        key(9'h05A);
        idle(3);
        check_eq("plan1_not_yet", bus_a.out_valid, 1'b0);
        idle(1);
        check_eq("plan1_valid", bus_a.out_valid, 1'b1);
        check_eq("plan1_value", bus_a.out_value, 123);
        check_eq("plan1_busy",  bus_a.busy,      1'b1);
        idle(4); key(9'h016); key(9'h076); idle(4);
        check_eq("plan2_held", bus_a.out_value, 123);
        cycle(1'b0, 9'h000, 1'b1);
        check_eq("plan2_cleared", bus_a.digits, 16'hFFFF);
        check_eq("plan2_idle",    bus_a.busy,   1'b0);

        // Overflow, backspace, clear
        key(9'h046); key(9'h03E); key(9'h03D); key(9'h036); key(9'h02E);
        check_eq("plan3_digits", bus_a.digits,   16'h9876);
        check_eq("plan3_ovf",    bus_a.overflow, 1'b1);
        key(9'h066);
        check_eq("plan3_bs", bus_a.digits, 16'hF987);
        key(9'h076);
        check_eq("plan3_esc", bus_a.digits, 16'hFFFF);

        // Keypad entry with keypad Enter
        key(9'h069); key(9'h070); key(9'h070); key(9'h15A);
        idle(4);
        check_eq("plan4_value", bus_a.out_value, 100);
        cycle(1'b0, 9'h000, 1'b1);

        // Keypad digits ignored when the keypad is disabled
        cycle_b(1'b1, 9'h069, 1'b0); cycle_b(1'b1, 9'h070, 1'b0);
        cycle_b(1'b1, 9'h070, 1'b0); cycle_b(1'b1, 9'h15A, 1'b0);
        check_eq("b_busy",   bus_b.busy,   1'b0);
        check_eq("b_count",  bus_b.count,  0);
        check_eq("b_digits", bus_b.digits, 16'hFFFF);
        cycle_b(1'b1, 9'h016, 1'b0); cycle_b(1'b1, 9'h15A, 1'b0);
        for (int i = 0; i < 4; i++) cycle_b(1'b0, 9'h000, 1'b0);
        check_eq("b_valid", bus_b.out_valid, 1'b1);
        check_eq("b_value", bus_b.out_value, 1);
        cycle_b(1'b0, 9'h000, 1'b1);
        check_eq("b_accepted", bus_b.out_valid, 1'b0);

        // No-ops on an empty buffer
        key(9'h05A); key(9'h066); key(9'h01C);
        check_eq("plan5_busy",  bus_a.busy,  1'b0);
        check_eq("plan5_count", bus_a.count, 0);

        // Reset in the middle of a conversion
        key(9'h025); key(9'h01E); key(9'h05A);
        idle(2);
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_a();
        check_eq("plan6_busy", bus_a.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        key(9'h03D); key(9'h05A);
        idle(4);
        check_eq("plan6_value", bus_a.out_value, 7);
        cycle(1'b0, 9'h000, 1'b1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40)      kc = 9'(main_codes[$urandom_range(0, 9)]);
            else if (r < 55) kc = 9'(keypad_codes[$urandom_range(0, 9)]);
            else if (r < 65) kc = 9'h066;
            else if (r < 68) kc = 9'h076;
            else if (r < 78) kc = ($urandom_range(0, 1) == 0) ? 9'h05A : 9'h15A;
            else             kc = 9'($urandom);
            cycle(1'($urandom_range(0, 1)), kc, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
